// File: rtl/div_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : div_seq_ctrl_if
//  Purpose  : Handshake/operand bundle between the EX stage and the
//             divide sequencer.
//  Ports    : start, op_rem, op_w, is_signed, src1, src2, flush  (EX -> div)
//             stall, busy, result, result_valid                  (div -> EX)
//  Modports : master = EX stage / bench side, slave = sequencer side
//  Revision : 1.0  initial release
// ============================================================================
interface div_seq_ctrl_if;
  logic        start;
  logic        op_rem;
  logic        op_w;
  logic        is_signed;
  logic [63:0] src1;
  logic [63:0] src2;
  logic        flush;
  logic        stall;
  logic        busy;
  logic [63:0] result;
  logic        result_valid;

  modport master (
    output start, op_rem, op_w, is_signed, src1, src2, flush,
    input  stall, busy, result, result_valid
  );

  modport slave (
    input  start, op_rem, op_w, is_signed, src1, src2, flush,
    output stall, busy, result, result_valid
  );
endinterface
`default_nettype wire

// File: rtl/div_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : div_seq_ctrl
//  Purpose  : RV64M divide/remainder sequencer. Restoring divider producing
//             one quotient bit per cycle, with RISC-V divide-by-zero and
//             signed-overflow handling, pipeline stall and flush abort.
//  Ports    : clk  - system clock (rising edge)
//             rst  - synchronous active-high reset
//             bus  - div_seq_ctrl_if.slave (operands, mode, flush in;
//                    stall, busy, result, result_valid out)
//  Revision : 1.0  initial release
// ============================================================================
module div_seq_ctrl (
  input  logic               clk,
  input  logic               rst,
  div_seq_ctrl_if.slave      bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [5:0]  cnt;
  logic [63:0] rem, quo, dvs, result;
  logic        l_rem, l_w, neg_q, neg_r;
  logic        stall_c, busy_c, valid_c;

  // Word results are always sign-extended from bit 31.
  function automatic logic [63:0] sext_w(input logic w, input logic [63:0] x);
    return w ? {{32{x[31]}}, x[31:0]} : x;
  endfunction

  // ---------------- operand preparation (from live inputs, used in IDLE)
  logic [63:0] a_eff, b_eff, a_neg, b_neg, a_abs, b_abs;
  logic        a_sign, b_sign, b_zero, ovf, special;
  logic [63:0] sp_q, sp_r, special_result;

  always_comb begin
    a_eff  = bus.op_w ? {32'd0, bus.src1[31:0]} : bus.src1;
    b_eff  = bus.op_w ? {32'd0, bus.src2[31:0]} : bus.src2;
    a_sign = bus.is_signed & (bus.op_w ? bus.src1[31] : bus.src1[63]);
    b_sign = bus.is_signed & (bus.op_w ? bus.src2[31] : bus.src2[63]);
    a_neg  = 64'd0 - a_eff;
    b_neg  = 64'd0 - b_eff;
    // For word ops only the low 32 bits of the negation are the magnitude.
    a_abs  = a_sign ? (bus.op_w ? {32'd0, a_neg[31:0]} : a_neg) : a_eff;
    b_abs  = b_sign ? (bus.op_w ? {32'd0, b_neg[31:0]} : b_neg) : b_eff;
    b_zero = (b_eff == 64'd0);
    ovf    = bus.is_signed &
             (bus.op_w ? (bus.src1[31:0] == 32'h8000_0000 && bus.src2[31:0] == 32'hFFFF_FFFF)
                       : (bus.src1 == 64'h8000_0000_0000_0000 && bus.src2 == 64'hFFFF_FFFF_FFFF_FFFF));
    special = b_zero | ovf;
    // Divide-by-zero takes precedence; overflow needs a non-zero divisor anyway.
    sp_q = b_zero ? 64'hFFFF_FFFF_FFFF_FFFF : a_eff;
    sp_r = b_zero ? a_eff : 64'd0;
    special_result = sext_w(bus.op_w, bus.op_rem ? sp_r : sp_q);
  end

  // ---------------- one restoring step
  // rem < dvs always holds, so the 65-bit trial never overflows its sign bit.
  logic [64:0] shifted, trial;
  logic [63:0] step_rem, step_quo, q_raw, q_fin, r_fin, fin_result;

  always_comb begin
    shifted    = {rem, quo[63]};
    trial      = shifted - {1'b0, dvs};
    step_rem   = trial[64] ? shifted[63:0] : trial[63:0];
    step_quo   = {quo[62:0], ~trial[64]};
    // Word dividends are left-aligned in quo, so after 32 steps only the
    // low half holds quotient bits.
    q_raw      = l_w ? {32'd0, step_quo[31:0]} : step_quo;
    q_fin      = neg_q ? (64'd0 - q_raw) : q_raw;
    r_fin      = neg_r ? (64'd0 - step_rem) : step_rem;
    fin_result = sext_w(l_w, l_rem ? r_fin : q_fin);
  end

  // ---------------- FSM
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    stall_c    = 1'b0;
    busy_c     = 1'b0;
    valid_c    = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start && !bus.flush) begin
          stall_c    = 1'b1;
          state_next = special ? S_DONE : S_BUSY;
        end
      end
      S_BUSY: begin
        stall_c = 1'b1;
        busy_c  = 1'b1;
        if (cnt == 6'd0) state_next = S_DONE;
      end
      S_DONE: begin
        valid_c    = ~bus.flush;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    if (bus.flush) state_next = S_IDLE;
  end

  // ---------------- datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= 6'd0;
      result <= 64'd0;
      rem    <= 64'd0;
      quo    <= 64'd0;
      dvs    <= 64'd0;
      l_rem  <= 1'b0;
      l_w    <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
    end else if (bus.flush) begin
      cnt <= 6'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            l_rem <= bus.op_rem;
            l_w   <= bus.op_w;
            neg_q <= a_sign ^ b_sign;
            neg_r <= a_sign;
            dvs   <= b_abs;
            rem   <= 64'd0;
            quo   <= bus.op_w ? {a_abs[31:0], 32'd0} : a_abs;
            if (special) result <= special_result;
            else         cnt    <= bus.op_w ? 6'd31 : 6'd63;
          end
        end
        S_BUSY: begin
          rem <= step_rem;
          quo <= step_quo;
          if (cnt == 6'd0) result <= fin_result;
          else             cnt    <= cnt - 6'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.stall        = stall_c;
  assign bus.busy         = busy_c;
  assign bus.result_valid = valid_c;
  assign bus.result       = result;

endmodule
`default_nettype wire

// File: tb/tb_div_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_div_seq_ctrl
//  Purpose  : Scoreboard bench for div_seq_ctrl. Stimulus pushes expected
//             result and completion cycle; a monitor pops on result_valid.
//  Revision : 1.0  initial release
// ============================================================================
module tb_div_seq_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic [63:0] last_res;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  div_seq_ctrl_if bus();

  div_seq_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [63:0] res;
    int          due;
  } exp_t;
  exp_t sbq[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: RISC-V divide semantics with plain arithmetic.
  function automatic logic [63:0] ref_div(input bit rm, input bit w, input bit sg,
                                          input logic [63:0] a, input logic [63:0] b);
    logic [31:0] a32, b32, q32, r32;
    logic [63:0] q, r;
    if (w) begin
      a32 = a[31:0];
      b32 = b[31:0];
      if (b32 == 0) begin
        q32 = 32'hFFFF_FFFF; r32 = a32;
      end else if (sg && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
        q32 = a32; r32 = 0;
      end else if (sg) begin
        q32 = $signed(a32) / $signed(b32);
        r32 = $signed(a32) % $signed(b32);
      end else begin
        q32 = a32 / b32;
        r32 = a32 % b32;
      end
      return rm ? {{32{r32[31]}}, r32} : {{32{q32[31]}}, q32};
    end
    if (b == 0) begin
      q = 64'hFFFF_FFFF_FFFF_FFFF; r = a;
    end else if (sg && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) begin
      q = a; r = 0;
    end else if (sg) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return rm ? r : q;
  endfunction

  function automatic bit is_special(input bit w, input bit sg, input logic [63:0] a, input logic [63:0] b);
    if (w) return (b[31:0] == 0) || (sg && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
    return (b == 0) || (sg && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF);
  endfunction

  // Monitor: every result_valid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus.result_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: result %h with no outstanding op (cycle %0d)", bus.result, cyc);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("result", bus.result, e.res);
        check("valid_cycle", 64'(cyc), 64'(e.due));
      end
    end
  end

  // Called at a negedge with the sequencer in IDLE.
  task automatic issue(input bit rm, input bit w, input bit sg,
                       input logic [63:0] a, input logic [63:0] b);
    int   c, n, stall_cnt, busy_cnt, waited;
    bit   sp;
    exp_t e;
    bus.start = 1'b1; bus.op_rem = rm; bus.op_w = w; bus.is_signed = sg;
    bus.src1 = a; bus.src2 = b;
    c  = cyc;
    n  = w ? 32 : 64;
    sp = is_special(w, sg, a, b);
    e.res = ref_div(rm, w, sg, a, b);
    e.due = sp ? c + 1 : c + n + 1;
    sbq.push_back(e);
    last_res = e.res;
    #1;
    stall_cnt = 0; busy_cnt = 0; waited = 0;
    while (bus.result_valid !== 1'b1 && waited < 200) begin
      if (bus.stall === 1'b1) stall_cnt++;
      if (bus.busy === 1'b1) busy_cnt++;
      @(negedge clk);
      waited++;
    end
    if (waited >= 200) begin
      checks++;
      errors++;
      $display("FAIL timeout: no result_valid after %0d cycles, required within %0d", waited, n + 1);
    end
    check("stall_cycles", 64'(stall_cnt), sp ? 64'd1 : 64'(n + 1));
    check("busy_cycles", 64'(busy_cnt), sp ? 64'd0 : 64'(n));
    check("stall_in_done", {63'd0, bus.stall}, 64'd0);
    bus.start = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int c;
    bit rm, w, sg;
    logic [63:0] a, b;
    rst = 1'b1;
    bus.start = 0; bus.op_rem = 0; bus.op_w = 0; bus.is_signed = 0;
    bus.src1 = 0; bus.src2 = 0; bus.flush = 0;
    repeat (3) @(negedge clk);
    check("reset_result", bus.result, 64'd0);
    check("reset_valid", {63'd0, bus.result_valid}, 64'd0);
    check("reset_stall", {63'd0, bus.stall}, 64'd0);
    check("reset_busy", {63'd0, bus.busy}, 64'd0);
    rst = 1'b0;
    last_res = 64'd0;
    @(negedge clk);

    // Directed cases
    issue(0, 0, 0, 64'd100, 64'd7);
    issue(1, 0, 0, 64'd100, 64'd7);
    issue(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2);
    issue(1, 0, 1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2);
    issue(0, 1, 1, 64'd1234, 64'hABCD_0000_0000);
    issue(1, 1, 1, 64'h1_8000_0005, 64'd0);
    issue(0, 0, 1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
    issue(1, 0, 1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
    issue(0, 1, 1, 64'h8000_0000, 64'hFFFF_FFFF);
    issue(0, 1, 0, 64'hFFFF_FFFF, 64'd1);

    // Flush at T+10 of a 64-bit div, then divu 9/3 at T+11
    bus.start = 1; bus.op_rem = 0; bus.op_w = 0; bus.is_signed = 1;
    bus.src1 = 64'd1000; bus.src2 = 64'd3;
    c = cyc;
    repeat (10) @(negedge clk);
    check("flush_cycle_offset", 64'(cyc - c), 64'd10);
    bus.flush = 1;
    #1;
    check("stall_in_flush_busy", {63'd0, bus.stall}, 64'd1);
    @(negedge clk);
    bus.flush = 0; bus.start = 0;
    #1;
    check("busy_after_flush", {63'd0, bus.busy}, 64'd0);
    check("result_kept_after_flush", bus.result, last_res);
    issue(0, 0, 0, 64'd9, 64'd3);

    // Reset at T+5 of another op
    bus.start = 1; bus.op_rem = 1; bus.op_w = 0; bus.is_signed = 0;
    bus.src1 = 64'd77; bus.src2 = 64'd5;
    repeat (5) @(negedge clk);
    rst = 1; bus.start = 0;
    @(negedge clk);
    check("rst_result", bus.result, 64'd0);
    check("rst_valid", {63'd0, bus.result_valid}, 64'd0);
    check("rst_stall", {63'd0, bus.stall}, 64'd0);
    check("rst_busy", {63'd0, bus.busy}, 64'd0);
    rst = 0;
    @(negedge clk);

    // Randomized ops with biased special cases
    for (int i = 0; i < 40; i++) begin
      rm = 1'($urandom_range(0, 1));
      w  = 1'($urandom_range(0, 1));
      sg = 1'($urandom_range(0, 1));
      a  = {$urandom, $urandom};
      b  = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0: b = w ? {b[63:32], 32'd0} : 64'd0;
        1: begin
          sg = 1;
          a = w ? {a[63:32], 32'h8000_0000} : 64'h8000_0000_0000_0000;
          b = w ? {b[63:32], 32'hFFFF_FFFF} : 64'hFFFF_FFFF_FFFF_FFFF;
        end
        2: begin
          a = 64'($urandom_range(0, 1000));
          b = 64'($urandom_range(1, 20));
          if ($urandom_range(0, 1) == 1) a = 64'd0 - a;
          if ($urandom_range(0, 1) == 1) b = 64'd0 - b;
        end
        default: ;
      endcase
      issue(rm, w, sg, a, b);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(sbq.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
